// File: rtl/bcd_wrap_counter.sv
// N-digit BCD wrap counter with a MIN_VAL..EMAX range. It counts ticks in run mode and emits a carry
// pulse on wrap. In set mode it takes manual up/down/load adjustments.
module bcd_wrap_counter #(
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned MIN_VAL     = 0,
    parameter int unsigned MAX_VAL     = 23,
    parameter bit          USE_DYN_MAX = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode_run,
    input  logic                tick_in,
    input  logic                up,
    input  logic                down,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic [4*DIGITS-1:0] max_dyn,
    output logic [4*DIGITS-1:0] value,
    output logic                tick_out,
    output logic                at_max
);

    localparam int unsigned W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int unsigned n);
        logic [W-1:0] r;
        int unsigned  x;
        r = '0;
        x = n;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VAL);
    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

    logic [W-1:0] value_q, value_d;
    logic         tick_q, tick_d;
    logic [W-1:0] emax;
    logic         below_min;
    logic         load_ok;

    assign emax = USE_DYN_MAX ? max_dyn : MAX_BCD;

    // Packed BCD orders like its decimal value, so plain unsigned compares work.
    if (MIN_VAL == 0) begin : g_min_zero
        assign below_min = 1'b0;
    end else begin : g_min_cmp
        assign below_min = load_val < MIN_BCD;
    end

    assign load_ok = bcd_valid(load_val) && !below_min && !(load_val > emax);

    always_comb begin
        value_d = value_q;
        tick_d  = 1'b0;
        if (USE_DYN_MAX && (value_q > emax)) begin
            value_d = emax;
        end else if (mode_run) begin
            if (tick_in) begin
                if (value_q == emax) begin
                    value_d = MIN_BCD;
                    tick_d  = 1'b1;
                end else begin
                    value_d = bcd_inc(value_q);
                end
            end
        end else if (load) begin
            if (load_ok) value_d = load_val;
        end else if (up && !down) begin
            value_d = (value_q == emax) ? MIN_BCD : bcd_inc(value_q);
        end else if (down && !up) begin
            value_d = (value_q == MIN_BCD) ? emax : bcd_dec(value_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= MIN_BCD;
            tick_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            tick_q  <= tick_d;
        end
    end

    assign value    = value_q;
    assign tick_out = tick_q;
    assign at_max   = (value_q == emax);

endmodule

// File: tb/tb_bcd_wrap_counter.sv
// Scoreboard bench for bcd_wrap_counter. Four configurations run side by side: hours, day-of-month,
// year and month. Directed scenarios come first, followed by randomized traffic.
module tb_bcd_wrap_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rst, mode_run, tick_in, up, down, load, tick_out, at_max;
    logic [15:0] load_val [4];
    logic [15:0] max_dyn  [4];
    logic [15:0] value    [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned D   = (g == 2) ? 4 : 2;
        localparam int unsigned W   = 4 * D;
        localparam int unsigned MN  = (g == 1 || g == 3) ? 1 : 0;
        localparam int unsigned MX  = (g == 0) ? 23 : (g == 1) ? 31 : (g == 2) ? 9999 : 12;
        localparam bit          DYN = (g == 1);
        logic [W-1:0] v;
        bcd_wrap_counter #(
            .DIGITS     (D),
            .MIN_VAL    (MN),
            .MAX_VAL    (MX),
            .USE_DYN_MAX(DYN)
        ) u_dut (
            .clk     (clk),
            .rst     (rst[g]),
            .mode_run(mode_run[g]),
            .tick_in (tick_in[g]),
            .up      (up[g]),
            .down    (down[g]),
            .load    (load[g]),
            .load_val(load_val[g][W-1:0]),
            .max_dyn (max_dyn[g][W-1:0]),
            .value   (v),
            .tick_out(tick_out[g]),
            .at_max  (at_max[g])
        );
        assign value[g] = 16'(v);
    end

    function automatic int cfg_dig(int g);
        return (g == 2) ? 4 : 2;
    endfunction
    function automatic int cfg_min(int g);
        return (g == 1 || g == 3) ? 1 : 0;
    endfunction
    function automatic int cfg_max(int g);
        return (g == 0) ? 23 : (g == 1) ? 31 : (g == 2) ? 9999 : 12;
    endfunction
    function automatic bit cfg_dyn(int g);
        return g == 1;
    endfunction

    function automatic logic [15:0] to_bcd(int n, int d);
        logic [15:0] r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic int bcd_to_int(logic [15:0] x, int d, output bit ok);
        int n = 0;
        int p = 1;
        ok = 1'b1;
        for (int i = 0; i < d; i++) begin
            int nib = int'(x[4*i +: 4]);
            if (nib > 9) ok = 1'b0;
            n = n + nib * p;
            p = p * 10;
        end
        return n;
    endfunction

    function automatic int emax_int(int g);
        bit ok;
        return cfg_dyn(g) ? bcd_to_int(max_dyn[g], 2, ok) : cfg_max(g);
    endfunction

    typedef struct packed {
        logic [3:0][15:0] v;
        logic [3:0]       t;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   mval[4];
    bit   mtick[4];
    int   nvec = 0;
    int   nerr = 0;

    function automatic void chk(string nm, int g, logic [15:0] act, logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s inst%0d t=%0t got %h want %h", nm, g, $time, act, exp);
        end
    endfunction

    // Decimal reference model; evaluated at the edge with the inputs the DUT sampled.
    task automatic model_step();
        for (int g = 0; g < 4; g++) begin
            int mn = cfg_min(g);
            int ex = emax_int(g);
            int lv;
            bit ok;
            mtick[g] = 1'b0;
            if (rst[g]) mval[g] = mn;
            else if (cfg_dyn(g) && mval[g] > ex) mval[g] = ex;
            else if (mode_run[g]) begin
                if (tick_in[g]) begin
                    if (mval[g] == ex) begin
                        mval[g]  = mn;
                        mtick[g] = 1'b1;
                    end else mval[g] = mval[g] + 1;
                end
            end else if (load[g]) begin
                lv = bcd_to_int(load_val[g], cfg_dig(g), ok);
                if (ok && lv >= mn && lv <= ex) mval[g] = lv;
            end else if (up[g] && !down[g]) mval[g] = (mval[g] == ex) ? mn : mval[g] + 1;
            else if (down[g] && !up[g]) mval[g] = (mval[g] == mn) ? ex : mval[g] - 1;
        end
    endtask

    task automatic clk_step();
        exp_t e;
        @(posedge clk);
        model_step();
        for (int g = 0; g < 4; g++) begin
            e.v[g] = to_bcd(mval[g], cfg_dig(g));
            e.t[g] = mtick[g];
        end
        sb.push_back(e);
        #1;
        rst     = '0;
        tick_in = '0;
        up      = '0;
        down    = '0;
        load    = '0;
    endtask

    task automatic set_load(int g, logic [15:0] lv);
        mode_run[g] = 1'b0;
        load[g]     = 1'b1;
        load_val[g] = lv;
        clk_step();
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            for (int g = 0; g < 4; g++) begin
                logic [15:0] em;
                em = cfg_dyn(g) ? max_dyn[g] : to_bcd(cfg_max(g), cfg_dig(g));
                chk("value", g, value[g], mon_e.v[g]);
                chk("tick_out", g, 16'(tick_out[g]), 16'(mon_e.t[g]));
                chk("at_max", g, 16'(at_max[g]), 16'(mon_e.v[g] == em));
            end
        end
    end

    initial begin
        rst      = '1;
        mode_run = '1;
        tick_in  = '1;
        up       = '0;
        down     = '0;
        load     = '0;
        for (int g = 0; g < 4; g++) begin
            load_val[g] = '0;
            max_dyn[g]  = '0;
        end
        max_dyn[1] = 16'h0031;
        clk_step();                       // reset wins over tick_in
        clk_step();                       // hold
        tick_in = '1;
        clk_step();                       // counting resumes

        // Hours: 19 -> 20,21,22,23,00 with carry; 09 -> 10; out-of-range load ignored
        set_load(0, 16'h0019);
        mode_run[0] = 1'b1;
        repeat (5) begin
            tick_in[0] = 1'b1;
            clk_step();
        end
        set_load(0, 16'h0009);
        mode_run[0] = 1'b1;
        tick_in[0]  = 1'b1;
        clk_step();
        set_load(0, 16'h0024);
        set_load(0, 16'h001F);

        // Day of month: 31 wraps to 01; clamp to a shrinking max_dyn; clamp beats up
        set_load(1, 16'h0031);
        mode_run[1] = 1'b1;
        tick_in[1]  = 1'b1;
        clk_step();
        set_load(1, 16'h0031);
        max_dyn[1] = 16'h0028;
        clk_step();
        max_dyn[1] = 16'h0031;
        set_load(1, 16'h0031);
        max_dyn[1] = 16'h0028;
        up[1]      = 1'b1;
        clk_step();
        max_dyn[1] = 16'h0031;

        // Month: set-mode wrap both ways, both buttons hold, ticks ignored
        set_load(3, 16'h0001);
        down[3] = 1'b1;
        clk_step();
        up[3] = 1'b1;
        clk_step();
        up[3]   = 1'b1;
        down[3] = 1'b1;
        clk_step();
        tick_in[3] = 1'b1;
        clk_step();

        // Year: digit ripple, full wrap, invalid digit load
        set_load(2, 16'h1999);
        mode_run[2] = 1'b1;
        tick_in[2]  = 1'b1;
        clk_step();
        set_load(2, 16'h9999);
        mode_run[2] = 1'b1;
        tick_in[2]  = 1'b1;
        clk_step();
        set_load(2, 16'h12A4);

        // Reset mid-count beats load
        mode_run[0] = 1'b1;
        repeat (3) begin
            tick_in[0] = 1'b1;
            clk_step();
        end
        rst[0]      = 1'b1;
        mode_run[0] = 1'b0;
        load[0]     = 1'b1;
        load_val[0] = 16'h0015;
        clk_step();

        repeat (3000) begin
            for (int g = 0; g < 4; g++) begin
                int d = cfg_dig(g);
                rst[g]      = ($urandom % 100) == 0;
                mode_run[g] = ($urandom % 4) != 0;
                tick_in[g]  = ($urandom % 4) != 0;
                up[g]       = ($urandom % 3) == 0;
                down[g]     = ($urandom % 3) == 0;
                load[g]     = ($urandom % 8) == 0;
                if ($urandom % 3 == 0) load_val[g] = 16'($urandom) & ((d == 4) ? 16'hFFFF : 16'h00FF);
                else load_val[g] = to_bcd(int'($urandom % ((d == 4) ? 10000 : 100)), d);
            end
            if ($urandom % 12 == 0) begin
                if ($urandom % 2 == 0) max_dyn[1] = to_bcd(int'($urandom_range(28, 31)), 2);
                else max_dyn[1] = to_bcd(int'($urandom_range(1, 99)), 2);
            end
            clk_step();
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 0, 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
